fir_access_sched: RTL

//   Scheduler in front of fir_filter: shares its single strobe interface between
//   a coefficient-reload requester and a sample-stream requester.

---
 rtl/fir_access_sched.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/fir_access_sched.sv
// Arbitrates fir_filter's single strobe interface between coefficient-bank reloads and sample issue.
// Optional transfer watchdog enabled by defining FIR_SCHED_TIMEOUT_EN.
module fir_access_sched #(
   parameter int DATA_W    = 16,
   parameter int NUM_COEFF = 4,
   parameter int TIMEOUT   = 255
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        cfg_valid,
   input  logic [NUM_COEFF*DATA_W-1:0] cfg_coeff,
   output logic                        cfg_ready,
   input  logic                        smp_valid,
   input  logic [DATA_W-1:0]           smp_data,
   output logic                        smp_ready,
   input  logic                        modwait,
   input  logic                        fir_err,
   output logic [DATA_W-1:0]           sample_data,
   output logic [DATA_W-1:0]           fir_coefficient,
   output logic                        data_ready,
   output logic                        load_coeff,
   output logic                        coeff_loaded,
   output logic                        busy,
   output logic                        err
);

   localparam int IDX_W = (NUM_COEFF > 1) ? $clog2(NUM_COEFF) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COEFF - 1);

   typedef enum logic [2:0] {IDLE, C_REQ, C_WAIT, S_REQ, S_WAIT, FAULT} state_t;

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic                cfg_full_q, cfg_full_d;
   logic                smp_full_q, smp_full_d;
   logic [DATA_W-1:0]   bank_q [NUM_COEFF];
   logic [DATA_W-1:0]   bank_d [NUM_COEFF];
   logic [DATA_W-1:0]   smp_q, smp_d;
   logic                coeff_loaded_q, coeff_loaded_d;
   logic                err_q, err_d;
   logic                load_coeff_q, load_coeff_d;
   logic                data_ready_q, data_ready_d;
   logic [DATA_W-1:0]   fir_coeff_q, fir_coeff_d;
   logic [DATA_W-1:0]   sample_data_q, sample_data_d;

   logic cfg_accept, smp_accept, timeout;
   logic cfg_clr, smp_clr, loaded_set, err_clr, to_fault;

   assign cfg_ready  = ~cfg_full_q;
   assign smp_ready  = ~smp_full_q && (state_q != FAULT);
   assign cfg_accept = cfg_valid && cfg_ready;
   assign smp_accept = smp_valid && smp_ready;

`ifdef FIR_SCHED_TIMEOUT_EN
   logic [7:0] cnt_q, cnt_d;
   logic       cnt_run;

   assign cnt_run = state_q inside {C_REQ, C_WAIT, S_REQ, S_WAIT};
   assign timeout = cnt_run && (cnt_q == 8'(TIMEOUT));

   always_comb begin
      cnt_d = cnt_q;
      if (state_d != state_q) cnt_d = '0;
      else if (cnt_run)       cnt_d = cnt_q + 8'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      cfg_clr    = 1'b0;
      smp_clr    = 1'b0;
      loaded_set = 1'b0;
      err_clr    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (cfg_full_q)                        state_d = C_REQ;
            else if (smp_full_q && coeff_loaded_q) state_d = S_REQ;
         end
         C_REQ:  if (modwait) state_d = C_WAIT;
         C_WAIT: begin
            if (!modwait) begin
               if (idx_q == LAST_IDX) begin
                  cfg_clr    = 1'b1;
                  loaded_set = 1'b1;
                  idx_d      = '0;
                  state_d    = IDLE;
               end else begin
                  idx_d   = idx_q + 1'b1;
                  state_d = C_REQ;
               end
            end
         end
         S_REQ:  if (modwait) state_d = S_WAIT;
         S_WAIT: begin
            if (!modwait) begin
               smp_clr = 1'b1;
               state_d = IDLE;
            end
         end
         FAULT: begin
            if (cfg_full_q) begin
               err_clr = 1'b1;
               idx_d   = '0;
               state_d = C_REQ;
            end
         end
         default: state_d = IDLE;
      endcase
      if (timeout) begin
         state_d    = FAULT;
         idx_d      = '0;
         cfg_clr    = 1'b0;
         smp_clr    = 1'b0;
         loaded_set = 1'b0;
      end
   end

   assign to_fault = (state_d == FAULT) && (state_q != FAULT);

   // A bank or sample accepted on the very cycle of a fault wins over the discard.
   always_comb begin
      cfg_full_d = cfg_full_q;
      if (cfg_accept)                cfg_full_d = 1'b1;
      else if (cfg_clr || to_fault)  cfg_full_d = 1'b0;

      smp_full_d = smp_full_q;
      if (smp_accept)                smp_full_d = 1'b1;
      else if (smp_clr || to_fault)  smp_full_d = 1'b0;

      bank_d = bank_q;
      if (cfg_accept)
         for (int unsigned i = 0; i < NUM_COEFF; i++)
            bank_d[i] = cfg_coeff[i*DATA_W +: DATA_W];

      smp_d = smp_accept ? smp_data : smp_q;

      coeff_loaded_d = coeff_loaded_q;
      if (cfg_accept || to_fault) coeff_loaded_d = 1'b0;
      else if (loaded_set)        coeff_loaded_d = 1'b1;

      err_d = err_q;
      if (to_fault)     err_d = 1'b1;
      else if (err_clr) err_d = 1'b0;

      load_coeff_d  = (state_q == C_REQ) && (state_d == C_REQ);
      data_ready_d  = (state_q == S_REQ) && (state_d == S_REQ);
      fir_coeff_d   = (state_q == C_REQ) ? bank_q[idx_q] : fir_coeff_q;
      sample_data_d = (state_q == S_REQ) ? smp_q : sample_data_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= IDLE;
         idx_q          <= '0;
         cfg_full_q     <= 1'b0;
         smp_full_q     <= 1'b0;
         for (int unsigned i = 0; i < NUM_COEFF; i++) bank_q[i] <= '0;
         smp_q          <= '0;
         coeff_loaded_q <= 1'b0;
         err_q          <= 1'b0;
         load_coeff_q   <= 1'b0;
         data_ready_q   <= 1'b0;
         fir_coeff_q    <= '0;
         sample_data_q  <= '0;
      end else begin
         state_q        <= state_d;
         idx_q          <= idx_d;
         cfg_full_q     <= cfg_full_d;
         smp_full_q     <= smp_full_d;
         bank_q         <= bank_d;
         smp_q          <= smp_d;
         coeff_loaded_q <= coeff_loaded_d;
         err_q          <= err_d;
         load_coeff_q   <= load_coeff_d;
         data_ready_q   <= data_ready_d;
         fir_coeff_q    <= fir_coeff_d;
         sample_data_q  <= sample_data_d;
      end
   end

   assign load_coeff      = load_coeff_q;
   assign data_ready      = data_ready_q;
   assign fir_coefficient = fir_coeff_q;
   assign sample_data     = sample_data_q;
   assign coeff_loaded    = coeff_loaded_q;
   assign busy            = (state_q != IDLE);
   assign err             = err_q | fir_err;

endmodule
